bitwise_issue_arbiter: RTL
==========================

// Module: bitwise_issue_arbiter
// PURPOSE
//  Shares one combinational Bitwise datapath (AND/OR/XOR/NOT/ROLL/ROLR/SHIFTL/SHIFTR/FLIP) between NREQ issue ports.
//  Round-robin arbitration, operand capture and result registration are done here.
//  Each result is returned on a single valid/ready response channel, tagged with its source port.
//  Sits between the issue stage and the Bitwise instance in the ALU cluster.
// PARAMETERS
//  NREQ   2  number of requesters (2..8)
//  TAG_W  4  width of per-request tag, returned unmodified
// PORTS
//  clk            in   1            clock, all state on rising edge
//  reset          in   1            asynchronous, active-high
//  req_valid      in   NREQ         per-port request valid
//  req_ready      out  NREQ         per-port accept; one-hot or zero
//  req_op         in   NREQ*opcode  per-port opcode_t, port i at slice i
//  req_size       in   NREQ*size    per-port sizeFlags_t
//  req_carry_in   in   NREQ         per-port carry input
//  req_use_carry  in   NREQ         per-port use-carry flag
//  req_a, req_b   in   NREQ*64      per-port operands (ulong_t)
//  req_tag        in   NREQ*TAG_W   per-port tag
//  alu_op/alu_size/alu_carry_in/alu_use_carry/alu_a/alu_b  out  -  to Bitwise, driven only from registers
//  alu_result     in   64           Bitwise result
//  alu_carry      in   1            Bitwise carry
//  rsp_valid      out  1            response valid
//  rsp_ready      in   1            response accept
//  rsp_result     out  64           registered result
//  rsp_carry      out  1            registered carry
//  rsp_tag        out  TAG_W        tag of the served request
//  rsp_src        out  $clog2(NREQ) index of the served port
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0.
//    All rsp_* and alu_* registers are 0. A reset mid-operation discards the in-flight op; no response is issued.
//  - FSM IDLE -> EXEC -> RESP.
//  - IDLE
//    - Grant = first valid port at or after rr_ptr, wrapping at NREQ-1 -> 0.
//    - req_ready[grant]=1 combinationally. Handshake = req_valid & req_ready.
//    - On handshake: latch op/size/carry_in/use_carry/a/b/tag/src into alu_* regs; go to EXEC.
//    - rr_ptr <= grant+1, mod NREQ.
//  - EXEC (exactly 1 cycle): alu_* stable.
//    - Capture alu_result/alu_carry into rsp_result/rsp_carry at the cycle end.
//    - Copy tag/src into rsp_tag/rsp_src. Go to RESP.
//  - RESP: rsp_valid=1. rsp_* must stay stable while rsp_ready=0 (backpressure, unbounded).
//    - rsp_ready=1 and no request valid: go to IDLE.
//    - rsp_ready=1 and a request is valid: arbitrate exactly as IDLE in the same cycle (req_ready may assert); go to EXEC.
//  - Latency: handshake cycle N -> rsp_valid at N+2. Max throughput 1 op / 2 cycles.
//  - req_ready is 0 in EXEC, and 0 in RESP while rsp_ready=0.
//  - Only one req_ready bit is ever set. Ports without a grant see no side effects.
//  - Simultaneous requests: port at rr_ptr wins, else next higher index, wrapping.
//    - A continuously valid port waits at most NREQ-1 grants.
//  - Ops, sizes and shift counts pass through untouched.
//    - Out-of-range size or unknown op gives whatever Bitwise returns (0 by its default). No error is flagged here.
//  - alu_* hold their last value outside EXEC; they may change only on a handshake.
// TESTING
//  1. Port0 XOR a=0xF0F0 b=0x0FF0 tag=3 at cycle N, rsp_ready=1 -> rsp_valid at N+2, result=0xFF00, carry=0, tag=3, src=0.
//  2. Ports 0 and 1 valid every cycle, rr_ptr=0 -> grants alternate 0,1,0,1. Never two req_ready bits high.
//  3. SHIFTL size=BITS_64 use_carry=0 a=1 b=4; hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, result=0x10 stable, req_ready=0.
//  4. rsp_ready=1 in RESP with port1 valid -> port1 accepted the same cycle, next rsp_valid two cycles later.
//     No idle bubble beyond EXEC.
//  5. Assert reset during EXEC -> rsp_valid=0, req_ready=0 immediately. Nothing emitted. Next request served normally, src starts from port 0.
//  6. NREQ=3, only port2 valid, rr_ptr=0 -> port2 granted, rr_ptr wraps to 0.

Source files
------------

// File: rtl/bitwise_issue_arbiter.sv
// bitwise_issue_arbiter: round-robin issue arbiter that shares one combinational Bitwise datapath
// between NREQ ports, registers operands and result, and returns tagged responses.
module bitwise_issue_arbiter #(
    parameter int NREQ = 2,
    parameter int TAG_W = 4,
    parameter int OP_W = 4,
    parameter int SIZE_W = 4,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*OP_W-1:0]    req_op,
    input  logic [NREQ*SIZE_W-1:0]  req_size,
    input  logic [NREQ-1:0]         req_carry_in,
    input  logic [NREQ-1:0]         req_use_carry,
    input  logic [NREQ*64-1:0]      req_a,
    input  logic [NREQ*64-1:0]      req_b,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic [OP_W-1:0]         alu_op,
    output logic [SIZE_W-1:0]       alu_size,
    output logic                    alu_carry_in,
    output logic                    alu_use_carry,
    output logic [63:0]             alu_a,
    output logic [63:0]             alu_b,
    input  logic [63:0]             alu_result,
    input  logic                    alu_carry,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_result,
    output logic                    rsp_carry,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [SRC_W-1:0]        rsp_src
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

    stateT            state, nextState;
    logic [SRC_W-1:0] rrPtr, grantIdx, aluSrc;
    logic [TAG_W-1:0] aluTag;
    logic             grantAny, canArb, handshake;

    function automatic logic [SRC_W-1:0] wrapIdx(input int v);
        return SRC_W'((v >= NREQ) ? v - NREQ : v);
    endfunction

    // Scan from the farthest offset down so the port closest to rrPtr wins.
    always_comb begin
        grantIdx = '0;
        grantAny = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrapIdx(int'(rrPtr) + k)]) begin
                grantIdx = wrapIdx(int'(rrPtr) + k);
                grantAny = 1'b1;
            end
        end
    end

    always_comb begin
        canArb = !reset && (state == IDLE || (state == RESP && rsp_ready));
        handshake = canArb && grantAny;
        req_ready = handshake ? (NREQ'(1) << grantIdx) : '0;
        rsp_valid = state == RESP;
        nextState = state == EXEC ? RESP
                  : handshake ? EXEC
                  : (state == RESP && !rsp_ready) ? RESP : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rrPtr <= '0;
        end else begin
            state <= nextState;
            if (handshake) rrPtr <= wrapIdx(int'(grantIdx) + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op <= '0;
            alu_size <= '0;
            alu_carry_in <= 1'b0;
            alu_use_carry <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            aluTag <= '0;
            aluSrc <= '0;
            rsp_result <= '0;
            rsp_carry <= 1'b0;
            rsp_tag <= '0;
            rsp_src <= '0;
        end else begin
            if (handshake) begin
                alu_op <= req_op[int'(grantIdx)*OP_W +: OP_W];
                alu_size <= req_size[int'(grantIdx)*SIZE_W +: SIZE_W];
                alu_carry_in <= req_carry_in[grantIdx];
                alu_use_carry <= req_use_carry[grantIdx];
                alu_a <= req_a[int'(grantIdx)*64 +: 64];
                alu_b <= req_b[int'(grantIdx)*64 +: 64];
                aluTag <= req_tag[int'(grantIdx)*TAG_W +: TAG_W];
                aluSrc <= grantIdx;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_carry <= alu_carry;
                rsp_tag <= aluTag;
                rsp_src <= aluSrc;
            end
        end
    end
endmodule
